uart_rx: RTL and testbench

8N1 UART receiver.
- Deserialises the serial line driven by uart_tx (or an external host) into bytes.
- Delivers each byte to the control logic over a single-entry valid/ready interface.
- Sits directly downstream of uart_tx on the rx path and shares its baud-rate parameterisation.
- Detects framing errors, false starts and overruns.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud
// divisor derivation used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   typedef struct packed {
      int unsigned clks_per_bit;
      int unsigned cnt_w;
   } baud_cfg_t;

   function automatic baud_cfg_t baud_cfg(input int unsigned clk_hz, input int unsigned baud_hz);
      baud_cfg_t c;
      c.clks_per_bit = clk_hz / baud_hz;
      c.cnt_w        = (c.clks_per_bit > 1) ? $clog2(c.clks_per_bit) : 1;
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Single-entry valid/ready byte channel from the UART receiver to its consumer.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to RST_VAL so an idle
// serial line reads as high straight out of reset.
module uart_sync2 #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry holding register
// with framing-error and overrun reporting.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY  = 125000000,
   parameter int unsigned UART_FREQUENCY = 9600
) (
   input  logic      user_clk,
   input  logic      rst_n,
   input  logic      rx_bit,
   uart_rx_if.master rx,
   output logic      frame_error,
   output logic      overrun,
   output logic      busy
);

   localparam baud_cfg_t CFG = baud_cfg(CLK_FREQUENCY, UART_FREQUENCY);
   localparam int CNT_W = int'(CFG.cnt_w);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CFG.clks_per_bit - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CFG.clks_per_bit / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_IDX  = BIT_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_t            state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [BIT_W-1:0]     bit_idx, bit_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 ferr_nxt, stop_ok, done;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;

   uart_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync (
      .clk   (user_clk),
      .rst_n (rst_n),
      .d     (rx_bit),
      .q     (rx_s)
   );

   always_ff @(posedge user_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_error <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_idx     <= bit_nxt;
         shift       <= shift_nxt;
         frame_error <= ferr_nxt;
         done        <= stop_ok;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      ferr_nxt  = 1'b0;
      stop_ok   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
               bit_nxt   = bit_idx + 1'b1;
               if (bit_idx == LAST_IDX) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  stop_ok   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            // a held-low line (break) yields one frame_error, not one per frame time
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // shift is untouched outside DATA, so it still holds the byte while done is high
   always_ff @(posedge user_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!valid_q || rx.ready) begin
               data_q  <= shift;
               valid_q <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid_q && rx.ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx.data  = data_q;
   assign rx.valid = valid_q;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven on negedges so arrival edges are exact; a
// cycle-level model of the holding register is derived from frame timing.
module tb_uart_rx;

   localparam int CLK_F  = 160;
   localparam int UART_F = 10;
   localparam int C      = CLK_F / UART_F;
   localparam int H      = C / 2;
   localparam int L      = 2 + H + 9 * C + 1;

   logic user_clk = 1'b0;
   logic rst_n    = 1'b0;
   logic rx_bit   = 1'b1;
   logic frame_error, overrun, busy;

   uart_rx_if rx_if ();

   uart_rx #(.CLK_FREQUENCY(CLK_F), .UART_FREQUENCY(UART_F)) dut (
      .user_clk    (user_clk),
      .rst_n       (rst_n),
      .rx_bit      (rx_bit),
      .rx          (rx_if),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 user_clk = ~user_clk;

   int n_vec = 0, n_err = 0, cyc = 0;
   int ferr_cnt = 0, ov_cnt = 0, ferr_exp = 0, vrise = -1;
   logic [7:0] done_at [int];
   logic [7:0] rcv_q [$];
   logic mv = 1'b0, mo, v_prev = 1'b0, rand_rdy = 1'b0, log_en = 1'b0;
   logic [7:0] md = 8'h00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected holding-register behaviour: bytes arrive L cycles after the start edge
   initial forever begin
      @(posedge user_clk);
      #1;
      cyc++;
      mo = 1'b0;
      if (!rst_n) begin
         mv = 1'b0;
         md = 8'h00;
      end else if (done_at.exists(cyc)) begin
         if (!mv || rx_if.ready) begin
            md = done_at[cyc];
            mv = 1'b1;
         end else begin
            mo = 1'b1;
         end
         done_at.delete(cyc);
      end else if (mv && rx_if.ready) begin
         mv = 1'b0;
      end
      check("valid", rx_if.valid, mv);
      check("data", rx_if.data, md);
      check("overrun", overrun, mo);
      if (frame_error) ferr_cnt++;
      if (overrun) ov_cnt++;
      if (rx_if.valid && !v_prev) vrise = cyc;
      v_prev = rx_if.valid;
      if (log_en && rx_if.valid) rcv_q.push_back(rx_if.data);
   end

   always @(negedge user_clk) if (rand_rdy) rx_if.ready = 1'($urandom_range(0, 1));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Call on a negedge; a bad frame leaves the line low after the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic good, input int abort_at);
      logic [9:0] fr;
      int key, t;
      fr  = {good, b, 1'b0};
      key = cyc + 1 + L;
      t   = 0;
      if (good) done_at[key] = b;
      else ferr_exp++;
      for (int i = 0; i < 10; i++) begin
         rx_bit = fr[i];
         for (int k = 0; k < C; k++) begin
            if (abort_at > 0 && t == abort_at) begin
               rst_n  = 1'b0;
               rx_bit = 1'b1;
               done_at.delete(key);
               if (!good) ferr_exp--;
               #1;
               check("rst_valid", rx_if.valid, 1'b0);
               check("rst_data", rx_if.data, 8'h00);
               check("rst_busy", busy, 1'b0);
               check("rst_ferr", frame_error, 1'b0);
               check("rst_ovr", overrun, 1'b0);
               repeat (3) @(negedge user_clk);
               rst_n = 1'b1;
               return;
            end
            @(negedge user_clk);
            t++;
         end
      end
   endtask

   initial begin
      int c0, gap;
      logic [7:0] b;
      logic good;
      rx_if.ready = 1'b0;
      repeat (3) @(negedge user_clk);
      check("reset_valid", rx_if.valid, 1'b0);
      check("reset_data", rx_if.data, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_ferr", frame_error, 1'b0);
      check("reset_ovr", overrun, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge user_clk);

      // single byte held until consumed, with exact latency
      c0 = cyc;
      send_frame(8'h80, 1'b1, 0);
      check("t1_latency", vrise - (c0 + 1), 155);
      check("t1_data", rx_if.data, 8'h80);
      repeat (5) @(negedge user_clk);
      check("t1_held", rx_if.valid, 1'b1);
      rx_if.ready = 1'b1;
      @(negedge user_clk);
      rx_if.ready = 1'b0;
      @(negedge user_clk);
      check("t1_cleared", rx_if.valid, 1'b0);

      // back-to-back frames, consumer always ready
      rx_if.ready = 1'b1;
      log_en = 1'b1;
      send_frame(8'h55, 1'b1, 0);
      send_frame(8'hA3, 1'b1, 0);
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      repeat (10) @(negedge user_clk);
      log_en = 1'b0;
      check("t2_count", rcv_q.size(), 4);
      if (rcv_q.size() == 4) begin
         check("t2_b0", rcv_q[0], 8'h55);
         check("t2_b1", rcv_q[1], 8'hA3);
         check("t2_b2", rcv_q[2], 8'h00);
         check("t2_b3", rcv_q[3], 8'hFF);
      end
      rx_if.ready = 1'b0;

      // bad stop bit followed by a break
      send_frame(8'h3C, 1'b0, 0);
      repeat (40) @(negedge user_clk);
      check("t3_busy_low_line", busy, 1'b1);
      check("t3_ferr_once", ferr_cnt, 1);
      check("t3_no_valid", rx_if.valid, 1'b0);
      rx_bit = 1'b1;
      repeat (4) @(negedge user_clk);
      check("t3_busy_released", busy, 1'b0);

      // glitch shorter than half a bit
      rx_bit = 1'b0;
      repeat (4) @(negedge user_clk);
      rx_bit = 1'b1;
      repeat (8) @(negedge user_clk);
      check("t4_busy", busy, 1'b0);
      check("t4_no_valid", rx_if.valid, 1'b0);
      check("t4_no_ferr", ferr_cnt, 1);

      // overrun, then replacement on the completion cycle
      send_frame(8'h11, 1'b1, 0);
      check("t5_first", rx_if.data, 8'h11);
      send_frame(8'h22, 1'b1, 0);
      check("t5_kept", rx_if.data, 8'h11);
      check("t5_ovr_once", ov_cnt, 1);
      c0 = cyc;
      fork
         send_frame(8'h33, 1'b1, 0);
         begin
            while (cyc < c0 + L) @(negedge user_clk);
            rx_if.ready = 1'b1;
            @(negedge user_clk);
            rx_if.ready = 1'b0;
         end
      join
      check("t5_replaced", rx_if.data, 8'h33);
      check("t5_valid", rx_if.valid, 1'b1);
      check("t5_no_ovr", ov_cnt, 1);
      rx_if.ready = 1'b1;
      @(negedge user_clk);
      rx_if.ready = 1'b0;

      // reset mid-frame, then a clean byte
      send_frame(8'hC4, 1'b1, 4 * C + 3);
      repeat (5) @(negedge user_clk);
      check("t6_aborted", rx_if.valid, 1'b0);
      send_frame(8'h5A, 1'b1, 0);
      check("t6_data", rx_if.data, 8'h5A);
      check("t6_valid", rx_if.valid, 1'b1);

      // randomized frames, gaps, stop errors and consumer stalls
      rand_rdy = 1'b1;
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 7) != 0);
         send_frame(b, good, 0);
         if (!good) begin
            repeat ($urandom_range(0, 20)) @(negedge user_clk);
            rx_bit = 1'b1;
            gap = $urandom_range(3, 20);
         end else begin
            gap = $urandom_range(0, 20);
         end
         repeat (gap) @(negedge user_clk);
      end
      rand_rdy = 1'b0;
      rx_if.ready = 1'b1;
      repeat (50) @(negedge user_clk);
      check("final_ferr_count", ferr_cnt, ferr_exp);
      check("final_pending", done_at.size(), 0);
      check("final_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
